// File: rtl/spi_px_stream.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_px_stream
//   Full-duplex SPI slave (mode 0, MSB first) front-end for the pixel core.
//   SCK, CS and SDI are oversampled in the clk_i domain through SYNC_STAGES
//   flops. Received PX_WIDTH-bit words show up on px_o with a one-cycle
//   px_valid_o strobe. At the same time the core's pixel (px_i) is shifted out
//   on spi_sdo_o. It is reloaded at CS fall and at every word boundary, so
//   back-to-back words stream without a gap.
//
// Parameters
//   PX_WIDTH    : bits per pixel word, both directions (default 24)
//   SYNC_STAGES : synchroniser depth on SCK/CS/SDI, 2..3 (default 2)
//
// Ports
//   clk_i      in   system clock, at least 4x SCK
//   nreset_i   in   asynchronous active-low reset
//   spi_sck_i  in   SPI clock (CPOL=0, CPHA=0)
//   spi_cs_i   in   chip select, active low
//   spi_sdi_i  in   serial data in, MSB first
//   spi_sdo_o  out  serial data out, MSB first (0 while idle)
//   px_o       out  last fully received pixel word
//   px_valid_o out  one-cycle strobe, px_o updated
//   px_i       in   processed pixel to transmit
//   px_load_o  out  one-cycle strobe, px_i captured into the TX shifter
//   busy_o     out  high while a CS frame is active
//
// Optional build macro
//   SPI_PX_LOOPBACK_EN : TX reloads take the most recently received word
//                        instead of px_i (SPI link bring-up).
// -----------------------------------------------------------------------------
module spi_px_stream #(
  parameter int PX_WIDTH    = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                nreset_i,
  input  logic                spi_sck_i,
  input  logic                spi_cs_i,
  input  logic                spi_sdi_i,
  output logic                spi_sdo_o,
  output logic [PX_WIDTH-1:0] px_o,
  output logic                px_valid_o,
  input  logic [PX_WIDTH-1:0] px_i,
  output logic                px_load_o,
  output logic                busy_o
);

  localparam int CW = (PX_WIDTH > 1) ? $clog2(PX_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PX_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Synchroniser chains, edge-detect delay flops and CS arming
  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] sdi_sync_r;
  logic [SYNC_STAGES-1:0] flush_r;
  logic                   sck_d_r;
  logic                   cs_d_r;
  logic                   cs_armed_r;

  // Frame engine state
  state_t                 state_r;
  logic [CW-1:0]          cnt_r;
  logic [PX_WIDTH-1:0]    rx_r;
  logic [PX_WIDTH-1:0]    tx_r;
  logic                   sdo_r;
  logic [PX_WIDTH-1:0]    px_r;
  logic                   valid_r;
  logic                   load_r;
  logic                   busy_r;
  logic                   pend_r;
  logic                   skip_fall_r;

  // Decoded synchronised pins and edges
  logic                   sck_s;
  logic                   cs_s;
  logic                   sdi_s;
  logic                   sck_rise_s;
  logic                   sck_fall_s;
  logic                   cs_fall_s;
  logic                   cs_rise_s;
  logic [PX_WIDTH-1:0]    start_word_s;
  logic [PX_WIDTH-1:0]    next_word_s;

  assign sck_s      = sck_sync_r[SYNC_STAGES-1];
  assign cs_s       = cs_sync_r[SYNC_STAGES-1];
  assign sdi_s      = sdi_sync_r[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_d_r;
  assign sck_fall_s = ~sck_s & sck_d_r;
  // A CS fall only counts once CS has been seen genuinely high after reset.
  // Otherwise a frame that was interrupted by reset would be picked up
  // mid-word.
  assign cs_fall_s  = cs_armed_r & ~cs_s & cs_d_r;
  assign cs_rise_s  = cs_s & ~cs_d_r;

`ifdef SPI_PX_LOOPBACK_EN
  // Loopback: the frame start sends the last delivered word. A word boundary
  // sends the word that has just completed, which is still held in rx_r.
  assign start_word_s = px_r;
  assign next_word_s  = rx_r;
`else
  assign start_word_s = px_i;
  assign next_word_s  = px_i;
`endif

  // Pin synchronisers, edge delay flops and post-reset CS arming
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      sck_sync_r <= '0;
      cs_sync_r  <= '1;
      sdi_sync_r <= '0;
      flush_r    <= '0;
      sck_d_r    <= 1'b0;
      cs_d_r     <= 1'b1;
      cs_armed_r <= 1'b0;
    end else begin
      sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], spi_sck_i};
      cs_sync_r  <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_i};
      sdi_sync_r <= {sdi_sync_r[SYNC_STAGES-2:0], spi_sdi_i};
      // flush_r tracks when the CS chain holds real pin samples, not reset values
      flush_r    <= {flush_r[SYNC_STAGES-2:0], 1'b1};
      sck_d_r    <= sck_s;
      cs_d_r     <= cs_s;
      if (flush_r[SYNC_STAGES-1] && cs_s) begin
        cs_armed_r <= 1'b1;
      end else begin
        cs_armed_r <= cs_armed_r;
      end
    end
  end

  // Frame FSM: deserialiser, serialiser, word delivery and strobes
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      rx_r        <= '0;
      tx_r        <= '0;
      sdo_r       <= 1'b0;
      px_r        <= '0;
      valid_r     <= 1'b0;
      load_r      <= 1'b0;
      busy_r      <= 1'b0;
      pend_r      <= 1'b0;
      skip_fall_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      load_r  <= 1'b0;

      // A word completed on the previous cycle is delivered now, even if
      // CS rises in this same cycle.
      if (pend_r) begin
        px_r    <= rx_r;
        valid_r <= 1'b1;
        pend_r  <= 1'b0;
      end else begin
        px_r    <= px_r;
      end

      case (state_r)
        IDLE: begin
          if (cs_fall_s) begin
            state_r     <= SHIFT;
            busy_r      <= 1'b1;
            tx_r        <= start_word_s;
            sdo_r       <= start_word_s[PX_WIDTH-1];
            load_r      <= 1'b1;
            cnt_r       <= '0;
            skip_fall_r <= 1'b0;
          end else begin
            busy_r      <= 1'b0;
            sdo_r       <= 1'b0;
          end
        end

        SHIFT: begin
          if (cs_rise_s) begin
            // CS wins over a coincident SCK edge; a partial word is dropped
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            cnt_r       <= '0;
            sdo_r       <= 1'b0;
            skip_fall_r <= 1'b0;
          end else begin
            if (pend_r) begin
              tx_r   <= next_word_s;
              sdo_r  <= next_word_s[PX_WIDTH-1];
              load_r <= 1'b1;
            end else if (sck_fall_s) begin
              if (skip_fall_r) begin
                // Trailing fall of the last bit: the new word's MSB must stay put
                skip_fall_r <= 1'b0;
              end else begin
                tx_r  <= {tx_r[PX_WIDTH-2:0], 1'b0};
                sdo_r <= tx_r[PX_WIDTH-2];
              end
            end else begin
              tx_r <= tx_r;
            end

            if (sck_rise_s) begin
              rx_r <= {rx_r[PX_WIDTH-2:0], sdi_s};
              if (cnt_r == CNT_LAST) begin
                cnt_r       <= '0;
                pend_r      <= 1'b1;
                skip_fall_r <= 1'b1;
              end else begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end else begin
              rx_r <= rx_r;
            end
          end
        end

        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
          sdo_r   <= 1'b0;
        end
      endcase
    end
  end

  assign spi_sdo_o  = sdo_r;
  assign px_o       = px_r;
  assign px_valid_o = valid_r;
  assign px_load_o  = load_r;
  assign busy_o     = busy_r;

endmodule

// File: tb/tb_spi_px_stream.sv
`timescale 1ns/1ps
// Directed testbench for spi_px_stream (PX_WIDTH=24, SYNC_STAGES=2).
// Inputs change on the falling clk edge. An SCK half-period is 8 clk cycles.
module tb_spi_px_stream;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sdi = 1'b0;
  logic        spi_sdo;
  logic [23:0] px_o;
  logic        px_valid;
  logic [23:0] px_i = 24'h0;
  logic        px_load;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Monitor-owned counters
  int          valid_cnt = 0;
  int          load_cnt = 0;
  logic [23:0] vals [0:63];

  spi_px_stream #(.PX_WIDTH(24), .SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .nreset_i   (nreset),
    .spi_sck_i  (spi_sck),
    .spi_cs_i   (spi_cs),
    .spi_sdi_i  (spi_sdi),
    .spi_sdo_o  (spi_sdo),
    .px_o       (px_o),
    .px_valid_o (px_valid),
    .px_i       (px_i),
    .px_load_o  (px_load),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Record strobes away from the active edge
  always @(negedge clk) begin
    if (px_valid) begin
      vals[valid_cnt[5:0]] <= px_o;
      valid_cnt <= valid_cnt + 1;
    end
    if (px_load) load_cnt <= load_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic s);
    spi_sdi = b;
    repeat (8) @(negedge clk);
    s = spi_sdo;
    spi_sck = 1'b1;
    repeat (8) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic send_word(input logic [23:0] w, output logic [23:0] so);
    logic b;
    for (int i = 23; i >= 0; i--) begin
      send_bit(w[i], b);
      so[i] = b;
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (8) @(negedge clk);
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [23:0] so, so1, so2, so3, w;
    logic        b;
    int          vbase, lbase;
    logic [23:0] exp_t1, exp_w2, exp_w3;

`ifdef SPI_PX_LOOPBACK_EN
    exp_t1 = 24'h000000;
    exp_w2 = 24'h000001;
    exp_w3 = 24'h800000;
`else
    exp_t1 = 24'h123456;
    exp_w2 = 24'h654321;
    exp_w3 = 24'h654321;
`endif

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_px", {8'h0, px_o}, 32'h0);
    check("rst_valid", {31'h0, px_valid}, 32'h0);
    check("rst_load", {31'h0, px_load}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_sdo", {31'h0, spi_sdo}, 32'h0);
    nreset = 1'b1;
    repeat (6) @(negedge clk);

    // ---- single word 0xA5C3F0 with px_i = 0x123456, latency checks ----
    px_i = 24'h123456;
    w = 24'hA5C3F0;
    vbase = valid_cnt;
    lbase = load_cnt;
    cs_low();
    check("load_at_cs_fall", load_cnt - lbase, 32'd1);
    check("busy_in_frame", {31'h0, busy}, 32'h1);
    for (int i = 23; i >= 1; i--) begin
      send_bit(w[i], b);
      so[i] = b;
    end
    spi_sdi = w[0];
    repeat (8) @(negedge clk);
    so[0] = spi_sdo;
    spi_sck = 1'b1;
    repeat (3) @(negedge clk);
    check("valid_early", {31'h0, px_valid}, 32'h0);
    @(negedge clk);
    check("valid_at_lat4", {31'h0, px_valid}, 32'h1);
    @(negedge clk);
    check("valid_one_cycle", {31'h0, px_valid}, 32'h0);
    repeat (3) @(negedge clk);
    spi_sck = 1'b0;
    repeat (8) @(negedge clk);
    spi_cs = 1'b1;
    repeat (2) @(negedge clk);
    check("busy_before_lat3", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("busy_fall_lat3", {31'h0, busy}, 32'h0);
    repeat (8) @(negedge clk);
    check("t1_valid_count", valid_cnt - vbase, 32'd1);
    check("t1_px", {8'h0, px_o}, {8'h0, 24'hA5C3F0});
    check("t1_sdo", {8'h0, so}, {8'h0, exp_t1});
    check("t1_load_count", load_cnt - lbase, 32'd2);
    check("idle_sdo", {31'h0, spi_sdo}, 32'h0);

    // ---- three back-to-back words in one frame ----
    px_i = 24'h654321;
    vbase = valid_cnt;
    cs_low();
    send_word(24'h000001, so1);
    send_word(24'h800000, so2);
    send_word(24'hFFFFFF, so3);
    cs_high();
    check("b2b_count", valid_cnt - vbase, 32'd3);
    check("b2b_w0", {8'h0, vals[vbase[5:0]]}, {8'h0, 24'h000001});
    check("b2b_w1", {8'h0, vals[6'(vbase + 1)]}, {8'h0, 24'h800000});
    check("b2b_w2", {8'h0, vals[6'(vbase + 2)]}, {8'h0, 24'hFFFFFF});
    check("b2b_sdo2", {8'h0, so2}, {8'h0, exp_w2});
    check("b2b_sdo3", {8'h0, so3}, {8'h0, exp_w3});

    // ---- partial word discarded, counter cleared ----
    vbase = valid_cnt;
    cs_low();
    w = 24'h3FF000;
    for (int i = 23; i >= 14; i--) send_bit(w[i], b);
    cs_high();
    check("partial_no_valid", valid_cnt - vbase, 32'd0);
    check("partial_px_kept", {8'h0, px_o}, {8'h0, 24'hFFFFFF});
    cs_low();
    send_word(24'h0F0F0F, so);
    cs_high();
    check("after_partial_count", valid_cnt - vbase, 32'd1);
    check("after_partial_px", {8'h0, px_o}, {8'h0, 24'h0F0F0F});

    // ---- reset mid-word ----
    vbase = valid_cnt;
    cs_low();
    w = 24'hC0FFEE;
    for (int i = 23; i >= 12; i--) send_bit(w[i], b);
    nreset = 1'b0;
    #1;
    check("midrst_px", {8'h0, px_o}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_sdo", {31'h0, spi_sdo}, 32'h0);
    check("midrst_load", {31'h0, px_load}, 32'h0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (4) @(negedge clk);
    send_word(24'hFFFFFF, so);
    check("postrst_busy", {31'h0, busy}, 32'h0);
    check("postrst_no_valid", valid_cnt - vbase, 32'd0);
    check("postrst_px", {8'h0, px_o}, 32'h0);
    cs_high();
    cs_low();
    send_word(24'h3C3C3C, so);
    cs_high();
    check("fresh_frame_count", valid_cnt - vbase, 32'd1);
    check("fresh_frame_px", {8'h0, px_o}, {8'h0, 24'h3C3C3C});

`ifdef SPI_PX_LOOPBACK_EN
    // ---- loopback: second word echoes the first ----
    cs_low();
    send_word(24'hDEAD01, so1);
    send_word(24'h000000, so2);
    cs_high();
    check("loop_sdo1", {8'h0, so1}, {8'h0, 24'h3C3C3C});
    check("loop_sdo2", {8'h0, so2}, {8'h0, 24'hDEAD01});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_px_stream.md
Name: spi_px_stream

Overview:
- SPI slave front-end feeding pixels to the grayscale/Sobel core and returning processed pixels, full-duplex.
- Oversamples the SPI pins in the system clock domain and deserialises MSB-first words of PX_WIDTH bits into a parallel pixel with a one-cycle valid strobe.
- Simultaneously serialises the core's current output pixel on SDO.
- Sits between the chip IO pins and the pixel-processing core.

Parameters:
- PX_WIDTH, 24: bits per pixel word, both directions.
- SYNC_STAGES, 2: flip-flop stages on each of SCK, CS and SDI; legal values 2..3.

Ports:
- clk_i  input  1  system clock; must be at least 4x SCK frequency.
- nreset_i  input  1  asynchronous active-low reset.
- spi_sck_i  input  1  SPI clock; mode 0 (CPOL=0, CPHA=0).
- spi_cs_i  input  1  chip select, active low.
- spi_sdi_i  input  1  serial data in, MSB first.
- spi_sdo_o  output  1  serial data out, MSB first.
- px_o  output  PX_WIDTH  last fully received pixel word.
- px_valid_o  output  1  one-cycle strobe: px_o updated this cycle.
- px_i  input  PX_WIDTH  processed pixel from core, to be transmitted.
- px_load_o  output  1  one-cycle strobe: px_i captured into TX shifter.
- busy_o  output  1  high while CS is asserted (state SHIFT).

Behaviour:
- Reset (async assert, sync deassert handled upstream): every output is 0, state=IDLE, bit counter=0, RX/TX shifters=0, synchroniser flops=idle values (SCK=0, CS=1, SDI=0).
- Edge detection works on the synchronised signals only, comparing last sync stage vs a delay flop. Raw pins are never used in logic.
- States: IDLE, SHIFT.
- IDLE -> SHIFT on synced CS falling edge. That cycle:
  - TX shifter <= px_i; px_load_o=1.
  - bit counter <= 0; spi_sdo_o presents px_i[PX_WIDTH-1].
- SHIFT, synced SCK rising edge:
  - RX shifter <= {RX[PX_WIDTH-2:0], sdi_sync}; counter++.
  - If counter reaches PX_WIDTH-1 on this edge (word complete): next cycle px_o <= completed word, px_valid_o=1 for exactly one cycle, counter <= 0.
  - On that same cycle TX shifter <= px_i and px_load_o=1, so back-to-back words stream with no gap.
- SHIFT, synced SCK falling edge: TX shifter shifts left by 1; spi_sdo_o = TX MSB. The falling edge after the last bit is ignored; the reload already occurred.
- SHIFT -> IDLE on synced CS rising edge. A partial word (counter != 0) is discarded: no px_valid_o, px_o keeps its previous value. Counter cleared.
- spi_sdo_o = 0 in IDLE.
- busy_o = (state == SHIFT).
- Latency: pin SCK rise to internal sample = SYNC_STAGES+1 clk cycles. Last SCK rise to px_valid_o = SYNC_STAGES+2 cycles.
- Simultaneous synced CS rise and SCK rise in the same cycle: CS wins; the edge is not sampled.
- SCK edges while in IDLE are ignored.
- Reset mid-word: everything clears immediately, and no px_valid_o is generated.

Optional Feature:
- Macro SPI_PX_LOOPBACK_EN.
- Defined: every TX reload takes the most recently received word (px_o) instead of px_i. After reset the first word transmitted is 0. px_load_o still pulses. The Sobel path is untouched; this serves board bring-up of the SPI link.
- Undefined: TX reloads from px_i as specified above.

Test Plan:
- CS low, send 24 bits 0xA5C3F0, CS high -> exactly one px_valid_o pulse, px_o=0xA5C3F0, busy_o falls SYNC_STAGES+1 cycles after CS pin rise.
- px_i=0x123456 held, CS low, 24 SCK cycles -> SDO bits captured on SCK rising edges equal 0x123456 MSB first; px_load_o pulses once at CS fall and once at word end.
- Three back-to-back words 0x000001, 0x800000, 0xFFFFFF in one CS frame -> three px_valid_o pulses with those values in order, no extra or missing pulses.
- CS low, 10 bits, CS high -> no px_valid_o, px_o unchanged. Next full word 0x0F0F0F is received correctly, proving the counter cleared.
- nreset_i pulsed low after 12 bits -> all outputs 0 immediately. After release with CS still low, SCK edges are ignored until a fresh CS falling edge.
- With SPI_PX_LOOPBACK_EN defined, send 0xDEAD01 then 0x000000 in one frame -> second word's SDO is 0xDEAD01.
